// File: rtl/stc_dn_pkg.sv
// -----------------------------------------------------------------------------
// stc_dn_pkg
// Shared definitions for the sparse tensor core operand distribution networks
// (A and B side).
//   - Default element width, lanes per PE and PE count.
//   - lane_offset(): bit offset of a (pe, lane) element inside a flattened
//     broadcast word laid out PE-major, lane-minor.
// -----------------------------------------------------------------------------
package stc_dn_pkg;

  localparam int unsigned DN_DW_DATA = 16;  // bits per operand element
  localparam int unsigned DN_N       = 16;  // lanes per PE
  localparam int unsigned DN_N_PE    = 4;   // PEs fed by one vector

  // PE p owns n_lanes consecutive elements; lane l of PE p sits at element
  // index p*n_lanes + l.
  function automatic int unsigned lane_offset(
    input int unsigned pe,
    input int unsigned lane,
    input int unsigned n_lanes,
    input int unsigned dw
  );
    return (pe * n_lanes + lane) * dw;
  endfunction

endpackage : stc_dn_pkg

// File: rtl/stc_dn_stage.sv
// -----------------------------------------------------------------------------
// stc_dn_stage
// One stallable pipeline register of a distribution network. Holds a
// valid/last/data beat and accepts a new beat when it is empty or when its
// current beat leaves on the same edge, so bubbles are squeezed out.
//
// Ports
//   clk, rst_n     : clock, asynchronous active-low reset
//   in_valid_i     : upstream beat valid
//   in_last_i      : upstream beat is the last of its sequence
//   in_data_i[W]   : upstream broadcast word
//   in_ready_o     : this stage takes the upstream beat this cycle
//   out_valid_o    : held beat valid
//   out_last_o     : held beat is last (only meaningful with out_valid_o)
//   out_data_o[W]  : held broadcast word
//   out_ready_i    : downstream takes the held beat this cycle
// -----------------------------------------------------------------------------
module stc_dn_stage #(
  parameter int unsigned W = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  input  logic         in_last_i,
  input  logic [W-1:0] in_data_i,
  output logic         in_ready_o,
  output logic         out_valid_o,
  output logic         out_last_o,
  output logic [W-1:0] out_data_o,
  input  logic         out_ready_i
);

  logic         valid_q;
  logic         last_q;
  logic [W-1:0] data_q;

  assign in_ready_o = !valid_q || out_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data word is reset too (not just valid) because the
      // outputs must read all-zero while reset is asserted.
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else if (in_ready_o) begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, independent of statement order.
      valid_q <= in_valid_i;
      last_q  <= in_valid_i && in_last_i;
      // Data only moves with a real beat; a bubble leaves the old word
      // parked, which is harmless behind valid_q = 0.
      if (in_valid_i) begin
        data_q <= in_data_i;
      end
    end
  end

  assign out_valid_o = valid_q;
  assign out_last_o  = last_q;
  assign out_data_o  = data_q;

endmodule : stc_dn_stage

// File: rtl/stc_a_dn_pipe.sv
// -----------------------------------------------------------------------------
// stc_a_dn_pipe
// A-operand distribution network for the sparse tensor core. Accepts one
// N_PE-element A vector per valid/ready transfer, replays it for in_reuse+1
// beats, and broadcasts each masked element to the N lanes of its PE through
// an N_STAGE-deep fully stallable pipeline.
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous active-low reset
//   in_valid   : input vector valid
//   in_ready   : block accepts a vector this cycle
//   in_a       : A vector, PE p at [p*DW_DATA +: DW_DATA]
//   in_mask    : per-PE enable, 0 zeroes that PE's lanes
//   in_reuse   : output beats for this vector minus one
//   out_valid  : output beat valid
//   out_ready  : PE array accepts the beat
//   out_a      : PE p at [p*N*DW_DATA +: N*DW_DATA], N copies of its element
//   out_last   : final beat of the current vector
//
// Build option
//   STC_A_DN_ZERO_SKIP_EN : when defined, a vector whose masked elements are
//   all zero completes its handshake but produces no beats.
// -----------------------------------------------------------------------------
module stc_a_dn_pipe
  import stc_dn_pkg::*;
#(
  parameter int unsigned N       = DN_N,
  parameter int unsigned DW_DATA = DN_DW_DATA,
  parameter int unsigned N_PE    = DN_N_PE,
  parameter int unsigned N_STAGE = 2,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_PE*DW_DATA-1:0]   in_a,
  input  logic [N_PE-1:0]           in_mask,
  input  logic [CNT_W-1:0]          in_reuse,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_PE*N*DW_DATA-1:0] out_a,
  output logic                      out_last
);

  localparam int unsigned OW = N_PE * N * DW_DATA;

  // ---------------------------------------------------------------------------
  // Pipeline node bundle. Node 0 is the issue register, nodes 1..N_STAGE-1
  // are stc_dn_stage instances. node_rdy[k] means "whatever consumes node k
  // takes its beat this cycle".
  // ---------------------------------------------------------------------------
  logic          node_valid [N_STAGE];
  logic          node_last  [N_STAGE];
  logic [OW-1:0] node_data  [N_STAGE];
  logic          node_rdy   [N_STAGE];

  // ---------------------------------------------------------------------------
  // Issue register (stage 0)
  // ---------------------------------------------------------------------------
  logic                    issue_valid_q, issue_valid_d;
  logic [N_PE*DW_DATA-1:0] issue_a_q,     issue_a_d;
  logic [N_PE-1:0]         issue_mask_q,  issue_mask_d;
  logic [CNT_W-1:0]        issue_reuse_q, issue_reuse_d;
  logic [CNT_W-1:0]        issue_cnt_q,   issue_cnt_d;

  logic          issue_is_last;
  logic          issue_adv;
  logic          in_fire;
  logic          in_live;
  logic [OW-1:0] issue_word;

  assign issue_is_last = (issue_cnt_q == issue_reuse_q);
  assign issue_adv     = issue_valid_q && node_rdy[0];

  // The slot frees up on the edge that moves the last beat out, so a waiting
  // vector is taken with no bubble.
  assign in_ready = !issue_valid_q || (issue_is_last && issue_adv);
  assign in_fire  = in_valid && in_ready;

`ifdef STC_A_DN_ZERO_SKIP_EN
  // A vector only occupies the issue slot if some masked element is nonzero.
  always_comb begin
    in_live = 1'b0;
    for (int p = 0; p < int'(N_PE); p++) begin
      if (in_mask[p] && (in_a[p*DW_DATA +: DW_DATA] != '0)) begin
        in_live = 1'b1;
      end
    end
  end
`else
  assign in_live = 1'b1;
`endif

  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    issue_valid_d = issue_valid_q;
    issue_a_d     = issue_a_q;
    issue_mask_d  = issue_mask_q;
    issue_reuse_d = issue_reuse_q;
    issue_cnt_d   = issue_cnt_q;

    if (issue_adv) begin
      if (issue_is_last) begin
        issue_valid_d = 1'b0;
      end else begin
        issue_cnt_d = issue_cnt_q + CNT_W'(1);
      end
    end

    // Capture only happens when the slot is empty or its last beat is
    // leaving, so it cleanly overrides the advance above.
    if (in_fire) begin
      issue_valid_d = in_live;
      issue_a_d     = in_a;
      issue_mask_d  = in_mask;
      issue_reuse_d = in_reuse;
      issue_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issue_valid_q <= 1'b0;
      issue_a_q     <= '0;
      issue_mask_q  <= '0;
      issue_reuse_q <= '0;
      issue_cnt_q   <= '0;
    end else begin
      issue_valid_q <= issue_valid_d;
      issue_a_q     <= issue_a_d;
      issue_mask_q  <= issue_mask_d;
      issue_reuse_q <= issue_reuse_d;
      issue_cnt_q   <= issue_cnt_d;
    end
  end

  // Broadcast each masked element across its PE's N lanes.
  always_comb begin
    issue_word = '0;
    for (int p = 0; p < int'(N_PE); p++) begin
      for (int l = 0; l < int'(N); l++) begin
        issue_word[lane_offset(p, l, N, DW_DATA) +: DW_DATA] =
          issue_mask_q[p] ? issue_a_q[p*DW_DATA +: DW_DATA] : '0;
      end
    end
  end

  assign node_valid[0] = issue_valid_q;
  // Gated with valid so out_last reads 0 when N_STAGE=1 and the slot is empty.
  assign node_last[0]  = issue_valid_q && issue_is_last;
  assign node_data[0]  = issue_word;

  // ---------------------------------------------------------------------------
  // Stages 1..N_STAGE-1
  // ---------------------------------------------------------------------------
  for (genvar k = 1; k < int'(N_STAGE); k++) begin : g_stage
    stc_dn_stage #(
      .W (OW)
    ) u_stage (
      .clk         (clk),
      .rst_n       (reset),
      .in_valid_i  (node_valid[k-1]),
      .in_last_i   (node_last[k-1]),
      .in_data_i   (node_data[k-1]),
      .in_ready_o  (node_rdy[k-1]),
      .out_valid_o (node_valid[k]),
      .out_last_o  (node_last[k]),
      .out_data_o  (node_data[k]),
      .out_ready_i (node_rdy[k])
    );
  end : g_stage

  assign node_rdy[N_STAGE-1] = out_ready;

  assign out_valid = node_valid[N_STAGE-1];
  assign out_last  = node_last[N_STAGE-1];
  assign out_a     = node_data[N_STAGE-1];

endmodule : stc_a_dn_pipe

// File: doc/stc_a_dn_pipe.md
Name: stc_a_dn_pipe

Overview:
Next-generation A-operand distribution network for the sparse tensor core. It accepts one N_PE-wide vector of A values per transfer over a valid/ready handshake. It replays each vector for a programmable number of beats so A can be reused across B columns. Each value is broadcast to N lanes per PE, with per-PE masking. The block sits between the A operand buffer and the PE array's A inputs, and its output side is pipelined and fully stallable.

Parameters:
N, 16, lanes per PE receiving each broadcast A value
DW_DATA, 16, bits per A element
N_PE, 4, number of PEs (A elements per input vector)
N_STAGE, 2, registers from input to output including the issue register; legal range >= 1
CNT_W, 8, width of the reuse count

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
in_valid  input  1  input vector valid
in_ready  output  1  block can accept a vector this cycle
in_a  input  N_PE*DW_DATA  A vector; PE p uses bits [p*DW_DATA +: DW_DATA]
in_mask  input  N_PE  per-PE enable; 0 forces that PE's lanes to zero
in_reuse  input  CNT_W  number of output beats for this vector, minus 1
out_valid  output  1  output beat valid
out_ready  input  1  PE array accepts beat
out_a  output  N_PE*N*DW_DATA  PE p occupies slice [p*N*DW_DATA +: N*DW_DATA], holding N copies of the masked element
out_last  output  1  final beat of the current vector's reuse sequence

Behaviour:
- Reset (reset=0, asynchronous): all valid bits, beat counters, data and mask registers are cleared to 0. out_valid=0, out_a=0, out_last=0 immediately. in_ready=1 once reset=1.
- Transfer rules:
  - Input transfer occurs on a rising edge with in_valid && in_ready.
  - Output transfer occurs with out_valid && out_ready.
- Issue register (stage 0):
  - Captures in_a, in_mask, and in_reuse on an input transfer.
  - Beat counter starts at 0. The stage emits beats 0..in_reuse and tags the beat with count == in_reuse as last.
  - The counter increments each time stage 0 advances into stage 1 (or into the output when N_STAGE=1).
  - When the last beat advances, stage 0 empties unless a new vector is captured on the same edge.
- in_ready = !issue_valid || (issue_is_last && issue_advances). This gives back-to-back acceptance with no bubble when in_reuse=0 and out_ready=1.
- Stages 1..N_STAGE-1 carry the broadcast, masked word plus valid and last bits. Each stage advances when the next stage is empty or advancing; a bubble is squeezed out.
- Output is taken from the final register.
  - While out_valid && !out_ready, out_a, out_last, and out_valid hold stable.
  - out_valid never drops without a transfer.
- Latency: a vector accepted at edge k shows beat 0 on the outputs after edge k+N_STAGE-1, provided there is no backpressure. With N_STAGE=1, outputs are visible directly after the capture edge.
- Masking: a PE with mask=0 has all N lanes = 0 for every beat of that vector.
- Counter arithmetic is CNT_W-bit unsigned. in_reuse = 2^CNT_W-1 yields 2^CNT_W beats, with no wrap before last.
- Simultaneous events:
  - A last-beat advance and a new capture on the same edge: the new vector's beat 0 follows on the next advance, so throughput is 1 beat per cycle.
  - in_valid arriving while stalled: not accepted; the input must hold.

Optional Feature:
Macro STC_A_DN_ZERO_SKIP_EN.
- Defined: a vector whose masked elements are all zero is accepted (handshake completes) but generates no output beats; stage 0 stays or becomes empty and in_ready stays 1.
- Undefined: every accepted vector produces in_reuse+1 beats regardless of content.

Decomposition:
- Shared package stc_dn_pkg holds:
  - default DW_DATA, N, and N_PE constants
  - a lane-slice offset function (pe, lane) -> bit offset, shared with the B distribution network
- Sub-module stc_dn_stage: one stallable pipeline register with ports valid, last, and data (N_PE*N*DW_DATA). It is instantiated N_STAGE-1 times in a generate loop.

Test Plan:
All scenarios use defaults (N=16, DW_DATA=16, N_PE=4, N_STAGE=2).
- Reset: hold reset=0 for 3 cycles with random inputs -> out_valid=0, out_a=0, out_last=0; in_ready=1 after release.
- Single beat: in_a={16'h0004,16'h0003,16'h0002,16'h0001}, mask=4'hF, reuse=0, out_ready=1, accepted at edge k -> one beat after edge k+1 with PE0 lanes all 16'h0001 … PE3 lanes all 16'h0004; out_last=1.
- Reuse: reuse=2 -> 3 identical beats; out_last only on the third; in_ready=0 for 2 cycles; the next vector is accepted on the third beat's advance edge.
- Backpressure: stream 6 vectors with reuse=0 and out_ready=0 for cycles 3-7 -> in_ready drops after 2 vectors are held; outputs are stable while stalled; all 6 beats arrive in order with no loss or duplication.
- Mask: mask=4'b0101, in_a all 16'hFFFF -> PE0 and PE2 lanes 16'hFFFF, PE1 and PE3 lanes 0; with ZERO_SKIP_EN and mask=4'b0000 -> zero beats emitted.
- Reset mid-sequence: reuse=3, assert reset after beat 1 -> outputs clear immediately; after release there are no residual beats and in_ready=1.
